// File: rtl/pe_mac_os.sv
// pe_mac_os: parametrised systolic-array processing element.
//   mode 0 (OS): accumulates a framed dot product internally, then presents the
//                result on a valid/ready port.
//   mode 1 (PT): classic psum chain, c_out <= c_in + a*b.
// Operands and stream flags are forwarded east/south with one cycle of latency.
// Optional feature macro: PE_SAT_EN -- saturating accumulation plus a sticky
// sat_flag output; when undefined all sums wrap in two's complement.
module pe_mac_os #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              first_in,
  input  logic              last_in,
  input  logic [ACC_W-1:0]  c_in,
  input  logic              clr_err,
  input  logic              res_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              valid_out,
  output logic              first_out,
  output logic              last_out,
  output logic [ACC_W-1:0]  c_out,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_valid,
  output logic              err_seq,
  output logic              err_ovf
`ifdef PE_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  // The full-precision product must fit in the accumulator.
  generate
    if (ACC_W < 2 * DATA_W) begin : g_width_check
      $error("pe_mac_os: ACC_W must be >= 2*DATA_W");
    end
  endgenerate

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_ACC  = 1'b1;

  logic                       state_q, state_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;
  logic [ACC_W-1:0]           prod_ext;
  logic [ACC_W-1:0]           pt_term;
  logic [ACC_W-1:0]           pt_sum;
  logic [ACC_W-1:0]           acc_sum;
  logic                       load;
  logic [ACC_W-1:0]           load_val;
  logic                       seq_set;
  logic                       ovf_set;

  // Full-precision signed product, sign-extended to the accumulator width.
  assign a_ext    = (2*DATA_W)'($signed(a_in));
  assign b_ext    = (2*DATA_W)'($signed(b_in));
  assign prod     = a_ext * b_ext;
  assign prod_ext = ACC_W'(prod);
  assign pt_term  = in_valid ? prod_ext : '0;

`ifdef PE_SAT_EN
  logic pt_clamp, acc_clamp, os_clamp, sat_set;

  // Signed add that clamps to the representable range on overflow; the top
  // bit of the result reports whether a clamp happened.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] x,
                                             input logic [ACC_W-1:0] y);
    logic [ACC_W-1:0] s;
    logic             ovf;
    s   = x + y;
    ovf = (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
    if (ovf) s = x[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return {ovf, s};
  endfunction

  assign {pt_clamp, pt_sum}   = sat_add(c_in, pt_term);
  assign {acc_clamp, acc_sum} = sat_add(acc_q, prod_ext);
  assign sat_set              = (mode & in_valid & pt_clamp) | os_clamp;
`else
  assign pt_sum  = c_in + pt_term;
  assign acc_sum = acc_q + prod_ext;
`endif

  // Output-stationary framing FSM: decides accumulator update, result load
  // and framing errors for the current cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    load     = 1'b0;
    load_val = '0;
    seq_set  = 1'b0;
`ifdef PE_SAT_EN
    os_clamp = 1'b0;
`endif
    if (mode) begin
      // PT mode keeps the FSM idle; an open frame is abandoned.
      state_d = ST_IDLE;
      if (state_q == ST_ACC) seq_set = 1'b1;
    end else if (in_valid) begin
      if (first_in) begin
        // A first term inside an open frame discards the partial sum.
        if (state_q == ST_ACC) seq_set = 1'b1;
        if (last_in) begin
          load     = 1'b1;
          load_val = prod_ext;
          state_d  = ST_IDLE;
        end else begin
          acc_d   = prod_ext;
          state_d = ST_ACC;
        end
      end else if (state_q == ST_IDLE) begin
        seq_set = 1'b1;
      end else begin
`ifdef PE_SAT_EN
        os_clamp = acc_clamp;
`endif
        if (last_in) begin
          load     = 1'b1;
          load_val = acc_sum;
          state_d  = ST_IDLE;
        end else begin
          acc_d = acc_sum;
        end
      end
    end
  end

  // A load onto an unaccepted result loses that result.
  assign ovf_set = load & res_valid & ~res_ready;

  // East/south forwarding of operands and stream flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= '0;
      b_out     <= '0;
      valid_out <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      a_out     <= a_in;
      b_out     <= b_in;
      valid_out <= in_valid;
      first_out <= first_in;
      last_out  <= last_in;
    end
  end

  // Psum chain: add the product in PT mode, pass c_in through in OS mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c_out <= '0;
    else        c_out <= mode ? pt_sum : c_in;
  end

  // FSM state and running accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // Single-entry result register; a same-cycle load wins over acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (load) begin
      res_valid <= 1'b1;
      res_data  <= load_val;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Sticky error flags; clear has priority over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_seq  <= 1'b0;
      err_ovf  <= 1'b0;
`ifdef PE_SAT_EN
      sat_flag <= 1'b0;
`endif
    end else if (clr_err) begin
      err_seq  <= 1'b0;
      err_ovf  <= 1'b0;
`ifdef PE_SAT_EN
      sat_flag <= 1'b0;
`endif
    end else begin
      if (seq_set) err_seq  <= 1'b1;
      if (ovf_set) err_ovf  <= 1'b1;
`ifdef PE_SAT_EN
      if (sat_set) sat_flag <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_pe_mac_os.sv
// tb_pe_mac_os: scoreboard bench for pe_mac_os (DATA_W=16, ACC_W=32).
// The driver computes expectations from a frame-level reference model and
// queues them; negedge monitors pop and compare against the DUT outputs.
module tb_pe_mac_os;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode, in_valid, first_in, last_in, clr_err, res_ready;
  logic [15:0] a_in, b_in, a_out, b_out;
  logic [31:0] c_in, c_out, res_data;
  logic        valid_out, first_out, last_out, res_valid, err_seq, err_ovf;
`ifdef PE_SAT_EN
  logic        sat_flag;
`endif

  pe_mac_os #(.DATA_W(16), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .first_in(first_in), .last_in(last_in),
    .c_in(c_in), .clr_err(clr_err), .res_ready(res_ready),
    .a_out(a_out), .b_out(b_out), .valid_out(valid_out),
    .first_out(first_out), .last_out(last_out), .c_out(c_out),
    .res_data(res_data), .res_valid(res_valid),
    .err_seq(err_seq), .err_ovf(err_ovf)
`ifdef PE_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        v, f, l;
    logic [31:0] c;
    logic        seq, ovf, sat;
  } exp_t;

  exp_t        fwd_q[$];
  logic [31:0] res_q[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model state: is a frame open, and its running sum.
  bit     in_frame = 0;
  longint run_sum  = 0;
  bit     m_seq = 0, m_ovf = 0, m_sat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed 32-bit accumulate: clamp with PE_SAT_EN, otherwise wrap.
  function automatic longint model_add(input longint x, input longint y, output bit clamp);
    longint s;
    s     = x + y;
    clamp = 0;
`ifdef PE_SAT_EN
    if (s > 64'sd2147483647) begin
      s = 64'sd2147483647; clamp = 1;
    end else if (s < -64'sd2147483648) begin
      s = -64'sd2147483648; clamp = 1;
    end
`else
    s = longint'($signed(s[31:0]));
`endif
    return s;
  endfunction

  // Drive one cycle (called at posedge+1), update the model, queue expectations.
  task automatic drive(input bit m, input bit v, input bit f, input bit l,
                       input logic signed [15:0] a, input logic signed [15:0] b,
                       input logic signed [31:0] c, input bit rdy, input bit clr);
    exp_t   e;
    longint prod, sum, val;
    bit     cl;
    bit     seq_set, ovf_set, sat_set, load;
    seq_set = 0; ovf_set = 0; sat_set = 0; load = 0; val = 0; cl = 0;
    mode = m; in_valid = v; first_in = f; last_in = l;
    a_in = a; b_in = b; c_in = c; res_ready = rdy; clr_err = clr;
    prod = longint'(a) * longint'(b);
    sum  = longint'(c);
    if (m) begin
      if (in_frame) begin seq_set = 1; in_frame = 0; end
      if (v) begin sum = model_add(longint'(c), prod, cl); sat_set = cl; end
    end else if (v) begin
      if (f) begin
        if (in_frame) seq_set = 1;
        if (l) begin load = 1; val = prod; in_frame = 0; end
        else   begin run_sum = prod; in_frame = 1; end
      end else if (!in_frame) begin
        seq_set = 1;
      end else begin
        run_sum = model_add(run_sum, prod, cl);
        sat_set = cl;
        if (l) begin load = 1; val = run_sum; in_frame = 0; end
      end
    end
    if (load) begin
      if (res_q.size() > 0 && !rdy) begin
        res_q[res_q.size()-1] = val[31:0];
        ovf_set = 1;
      end else begin
        res_q.push_back(val[31:0]);
      end
    end
    m_seq = clr ? 1'b0 : (m_seq | seq_set);
    m_ovf = clr ? 1'b0 : (m_ovf | ovf_set);
    m_sat = clr ? 1'b0 : (m_sat | sat_set);
    e.a = a; e.b = b; e.v = v; e.f = f; e.l = l; e.c = sum[31:0];
    e.seq = m_seq; e.ovf = m_ovf; e.sat = m_sat;
    @(posedge clk);
    #1;
    fwd_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 16'sd0, 16'sd0, 32'sd0, rdy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_out"},     32'(a_out), 32'd0);
    check({tag, "_b_out"},     32'(b_out), 32'd0);
    check({tag, "_valid_out"}, 32'(valid_out), 32'd0);
    check({tag, "_first_out"}, 32'(first_out), 32'd0);
    check({tag, "_last_out"},  32'(last_out), 32'd0);
    check({tag, "_c_out"},     c_out, 32'd0);
    check({tag, "_res_data"},  res_data, 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_err_seq"},   32'(err_seq), 32'd0);
    check({tag, "_err_ovf"},   32'(err_ovf), 32'd0);
  endtask

  // Asynchronous reset for one cycle, applied away from the clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    mode = 0; in_valid = 0; first_in = 0; last_in = 0; clr_err = 0;
    fwd_q.delete(); res_q.delete();
    in_frame = 0; run_sum = 0; m_seq = 0; m_ovf = 0; m_sat = 0;
    #1;
    check_all_zero(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Per-cycle monitor: forwarding, psum and sticky flags.
  always @(negedge clk) begin
    if (rst_n && fwd_q.size() > 0) begin
      exp_t e;
      e = fwd_q.pop_front();
      check("a_out",     32'(a_out), 32'(e.a));
      check("b_out",     32'(b_out), 32'(e.b));
      check("valid_out", 32'(valid_out), 32'(e.v));
      check("first_out", 32'(first_out), 32'(e.f));
      check("last_out",  32'(last_out), 32'(e.l));
      check("c_out",     c_out, e.c);
      check("err_seq",   32'(err_seq), 32'(e.seq));
      check("err_ovf",   32'(err_ovf), 32'(e.ovf));
`ifdef PE_SAT_EN
      check("sat_flag",  32'(sat_flag), 32'(e.sat));
`endif
    end
  end

  // Result monitor: pops one expected result per accepted handshake.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (res_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL res_unexpected: got %0h expected none at %0t", res_data, $time);
      end else begin
        check("res_data", res_data, res_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    bit m, v, f, l, rdy, clr;
    rst_n = 1'b0;
    mode = 0; in_valid = 0; first_in = 0; last_in = 0;
    a_in = '0; b_in = '0; c_in = '0; clr_err = 0; res_ready = 0;
    #7;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2, 1);

    // OS dot product: 3*4 + -2*5 + 7*-1 = -5, visible right after the last edge.
    drive(0, 1, 1, 0, 16'sd3, 16'sd4, 32'sd0, 1, 0);
    drive(0, 1, 0, 0, -16'sd2, 16'sd5, 32'sd0, 1, 0);
    drive(0, 1, 0, 1, 16'sd7, -16'sd1, 32'sd0, 1, 0);
    check("os_latency_valid", 32'(res_valid), 32'd1);
    check("os_result", res_data, 32'hFFFF_FFFB);
    // Same frame with bubbles between terms.
    drive(0, 1, 1, 0, 16'sd3, 16'sd4, 32'sd0, 1, 0);
    idle(1, 1);
    drive(0, 1, 0, 0, -16'sd2, 16'sd5, 32'sd0, 1, 0);
    idle(2, 1);
    drive(0, 1, 0, 1, 16'sd7, -16'sd1, 32'sd0, 1, 0);
    check("os_bubble_result", res_data, 32'hFFFF_FFFB);
    idle(1, 1);
    check("os_accepted", 32'(res_valid), 32'd0);

    // PT psum chain.
    drive(1, 1, 0, 0, -16'sd3, 16'sd6, 32'sd100, 1, 0);
    check("pt_sum", c_out, 32'd82);
    drive(1, 0, 0, 0, -16'sd3, 16'sd6, 32'sd100, 1, 0);
    check("pt_bubble", c_out, 32'd100);
    check("pt_no_err", 32'(err_seq), 32'd0);

    // Overwrite of an unaccepted result.
    drive(0, 1, 1, 1, 16'sd2, 16'sd3, 32'sd0, 0, 0);
    drive(0, 1, 1, 1, 16'sd4, 16'sd5, 32'sd0, 0, 0);
    check("ovf_data", res_data, 32'd20);
    check("ovf_flag", 32'(err_ovf), 32'd1);
    idle(1, 1);
    drive(0, 0, 0, 0, 16'sd0, 16'sd0, 32'sd0, 1, 1);
    check("ovf_cleared", 32'(err_ovf), 32'd0);

    // Framing errors: orphan term, then a restart inside an open frame.
    drive(0, 1, 0, 0, 16'sd5, 16'sd5, 32'sd0, 1, 0);
    check("seq_orphan", 32'(err_seq), 32'd1);
    check("seq_orphan_nores", 32'(res_valid), 32'd0);
    drive(0, 1, 1, 0, 16'sd1, 16'sd1, 32'sd0, 1, 0);
    drive(0, 1, 0, 0, 16'sd2, 16'sd2, 32'sd0, 1, 0);
    drive(0, 1, 1, 0, 16'sd3, 16'sd3, 32'sd0, 1, 0);
    drive(0, 1, 0, 1, 16'sd4, 16'sd4, 32'sd0, 1, 0);
    check("seq_restart_result", res_data, 32'd25);
    drive(0, 0, 0, 0, 16'sd0, 16'sd0, 32'sd0, 1, 1);
    check("seq_cleared", 32'(err_seq), 32'd0);

    // Mode change to PT while a frame is open.
    drive(0, 1, 1, 0, 16'sd2, 16'sd2, 32'sd0, 1, 0);
    drive(1, 0, 0, 0, 16'sd0, 16'sd0, 32'sd7, 1, 0);
    check("mode_switch_err", 32'(err_seq), 32'd1);
    drive(0, 1, 1, 1, 16'sd6, 16'sd7, 32'sd0, 1, 1);
    check("mode_switch_next", res_data, 32'd42);

    // Extreme products: wrap or saturate.
    drive(0, 1, 1, 0, -16'sd32768, -16'sd32768, 32'sd0, 1, 0);
    drive(0, 1, 0, 0, -16'sd32768, -16'sd32768, 32'sd0, 1, 0);
    drive(0, 1, 0, 1, -16'sd32768, -16'sd32768, 32'sd0, 1, 0);
`ifdef PE_SAT_EN
    check("extreme_sat", res_data, 32'h7FFF_FFFF);
    check("extreme_sat_flag", 32'(sat_flag), 32'd1);
`else
    check("extreme_wrap", res_data, 32'hC000_0000);
`endif
    idle(1, 1);

    // Reset in the middle of a frame.
    drive(0, 1, 1, 0, 16'sd9, 16'sd9, 32'sd0, 1, 0);
    do_reset("midreset");
    drive(0, 1, 1, 0, 16'sd1, 16'sd2, 32'sd0, 1, 0);
    drive(0, 1, 0, 1, 16'sd3, 16'sd4, 32'sd0, 1, 0);
    check("post_reset_result", res_data, 32'd14);
    check("post_reset_noerr", 32'(err_seq), 32'd0);

    // Randomised traffic, everything checked by the monitors.
    for (int i = 0; i < 600; i++) begin
      m   = ($urandom_range(0, 99) < 12);
      v   = ($urandom_range(0, 99) < 75);
      f   = ($urandom_range(0, 99) < 25);
      l   = ($urandom_range(0, 99) < 30);
      rdy = ($urandom_range(0, 99) < 70);
      clr = ($urandom_range(0, 99) < 4);
      drive(m, v, f, l, 16'($urandom), 16'($urandom), 32'($urandom), rdy, clr);
    end

    // Drain the result register and confirm nothing was left behind.
    idle(3, 1);
    check("drain_empty", 32'(res_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
